// File: rtl/csr_pkg.sv
// Shared CSR definitions for the trap/MRET sequencer: CSR addresses,
// mstatus field positions, FSM state encoding and mstatus update helpers.
package csr_pkg;

  localparam int unsigned CSR_AW = 12;
  localparam int unsigned CSR_DW = 32;

  localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;
  localparam logic [CSR_AW-1:0] CSR_MTVAL   = 12'h343;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    IDLE,
    T_MEPC,
    T_MCAUSE,
    T_MTVAL,
    T_MSTATUS,
    R_MSTATUS,
    JUMP
  } state_e;

  // mstatus on trap entry: stack MIE into MPIE, disable interrupts, MPP = M
  function automatic logic [CSR_DW-1:0] trap_mstatus(input logic [CSR_DW-1:0] ms);
    logic [CSR_DW-1:0] r;
    r = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // mstatus on MRET: restore MIE from MPIE, set MPIE, MPP stays M
  function automatic logic [CSR_DW-1:0] mret_mstatus(input logic [CSR_DW-1:0] ms);
    logic [CSR_DW-1:0] r;
    r = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/csr_trap_sequencer_if.sv
// Request/CSR-write/pipeline-control bundle between the pipeline, the
// CSR file and csr_trap_sequencer.
interface csr_trap_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  PIPE_WREN;
  logic [ADDR_WIDTH-1:0] PIPE_WADDR;
  logic [DATA_WIDTH-1:0] PIPE_WDATA;
  logic                  TRAP_EN;
  logic [DATA_WIDTH-1:0] TRAP_CAUSE;
  logic [DATA_WIDTH-1:0] TRAP_PC;
  logic [DATA_WIDTH-1:0] TRAP_TVAL;
  logic                  MRET_EN;
  logic [DATA_WIDTH-1:0] MSTATUS_IN;
  logic [DATA_WIDTH-1:0] MTVEC_IN;
  logic [DATA_WIDTH-1:0] MEPC_IN;
  logic                  WREN;
  logic [ADDR_WIDTH-1:0] WADDR;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  STALL;
  logic                  FLUSH;
  logic                  JUMP_EN;
  logic [DATA_WIDTH-1:0] JUMP_PC;
  logic                  BUSY;

  modport master (
    output PIPE_WREN, PIPE_WADDR, PIPE_WDATA, TRAP_EN, TRAP_CAUSE, TRAP_PC, TRAP_TVAL,
           MRET_EN, MSTATUS_IN, MTVEC_IN, MEPC_IN,
    input  WREN, WADDR, WDATA, STALL, FLUSH, JUMP_EN, JUMP_PC, BUSY
  );

  modport slave (
    input  PIPE_WREN, PIPE_WADDR, PIPE_WDATA, TRAP_EN, TRAP_CAUSE, TRAP_PC, TRAP_TVAL,
           MRET_EN, MSTATUS_IN, MTVEC_IN, MEPC_IN,
    output WREN, WADDR, WDATA, STALL, FLUSH, JUMP_EN, JUMP_PC, BUSY
  );
endinterface

// File: rtl/csr_trap_target.sv
// Trap redirect target from mtvec and mcause: vectored for interrupts when
// mtvec mode is 01, otherwise the direct base address.
module csr_trap_target
  import csr_pkg::*;
(
  input  logic [CSR_DW-1:0] mtvec,
  input  logic [CSR_DW-1:0] cause,
  output logic [CSR_DW-1:0] target_c
);
  logic [CSR_DW-1:0] base;
  logic [CSR_DW-1:0] vec_off;

  always_comb begin
    base    = {mtvec[CSR_DW-1:2], 2'b00};
    vec_off = {1'b0, cause[CSR_DW-2:0]} << 2;
    if (mtvec[1:0] == 2'b01 && cause[CSR_DW-1]) target_c = base + vec_off;
    else                                         target_c = base;
  end
endmodule

// File: rtl/csr_trap_sequencer.sv
// Arbitrates the machine-mode CSR write port between pipeline writes and the
// trap-entry / MRET sequences. Define CSR_TRAP_MTVAL_EN to include the mtval write.
module csr_trap_sequencer
  import csr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic                CLK,
  input logic                RST,
  csr_trap_sequencer_if.slave bus
);
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] cause_q, cause_d, pc_q, pc_d;
  logic [DATA_WIDTH-1:0] mstatus_q, mstatus_d, mtvec_q, mtvec_d, mepc_q, mepc_d;
  logic                  mret_q, mret_d;
  logic                  wren_q, wren_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  stall_q, stall_d, flush_q, flush_d;
  logic                  jump_en_q, jump_en_d, busy_q, busy_d;
  logic [DATA_WIDTH-1:0] jump_pc_q, jump_pc_d;
  logic [DATA_WIDTH-1:0] trap_target_c;
`ifdef CSR_TRAP_MTVAL_EN
  logic [DATA_WIDTH-1:0] tval_q, tval_d;
`else
  logic unused_tval;
  assign unused_tval = ^bus.TRAP_TVAL;
`endif

  csr_trap_target u_target (
    .mtvec    (mtvec_q),
    .cause    (cause_q),
    .target_c (trap_target_c)
  );

  // Outputs are computed for the state being entered so they line up with state_q
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    pc_d      = pc_q;
    mstatus_d = mstatus_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mret_d    = mret_q;
`ifdef CSR_TRAP_MTVAL_EN
    tval_d    = tval_q;
`endif
    wren_d    = 1'b0;
    waddr_d   = '0;
    wdata_d   = '0;
    flush_d   = 1'b0;
    jump_en_d = 1'b0;
    jump_pc_d = '0;

    case (state_q)
      IDLE: begin
        if (bus.TRAP_EN) begin
          state_d   = T_MEPC;
          cause_d   = bus.TRAP_CAUSE;
          pc_d      = bus.TRAP_PC;
          mstatus_d = bus.MSTATUS_IN;
          mtvec_d   = bus.MTVEC_IN;
          mret_d    = 1'b0;
`ifdef CSR_TRAP_MTVAL_EN
          tval_d    = bus.TRAP_TVAL;
`endif
        end else if (bus.MRET_EN) begin
          state_d   = R_MSTATUS;
          mstatus_d = bus.MSTATUS_IN;
          mepc_d    = bus.MEPC_IN;
          mret_d    = 1'b1;
        end
      end
      T_MEPC: state_d = T_MCAUSE;
`ifdef CSR_TRAP_MTVAL_EN
      T_MCAUSE: state_d = T_MTVAL;
      T_MTVAL:  state_d = T_MSTATUS;
`else
      T_MCAUSE: state_d = T_MSTATUS;
`endif
      T_MSTATUS, R_MSTATUS: state_d = JUMP;
      default:  state_d = IDLE;
    endcase

    case (state_d)
      IDLE: begin
        if (state_q == IDLE && bus.PIPE_WREN) begin
          wren_d  = 1'b1;
          waddr_d = bus.PIPE_WADDR;
          wdata_d = bus.PIPE_WDATA;
        end
      end
      T_MEPC: begin
        wren_d  = 1'b1;
        waddr_d = ADDR_WIDTH'(CSR_MEPC);
        wdata_d = pc_d & ~DATA_WIDTH'(3);
      end
      T_MCAUSE: begin
        wren_d  = 1'b1;
        waddr_d = ADDR_WIDTH'(CSR_MCAUSE);
        wdata_d = cause_d;
      end
`ifdef CSR_TRAP_MTVAL_EN
      T_MTVAL: begin
        wren_d  = 1'b1;
        waddr_d = ADDR_WIDTH'(CSR_MTVAL);
        wdata_d = tval_d;
      end
`endif
      T_MSTATUS: begin
        wren_d  = 1'b1;
        waddr_d = ADDR_WIDTH'(CSR_MSTATUS);
        wdata_d = DATA_WIDTH'(trap_mstatus(CSR_DW'(mstatus_d)));
      end
      R_MSTATUS: begin
        wren_d  = 1'b1;
        waddr_d = ADDR_WIDTH'(CSR_MSTATUS);
        wdata_d = DATA_WIDTH'(mret_mstatus(CSR_DW'(mstatus_d)));
      end
      JUMP: begin
        flush_d   = 1'b1;
        jump_en_d = 1'b1;
        jump_pc_d = mret_d ? mepc_d : trap_target_c;
      end
      default: ;
    endcase

    stall_d = (state_d != IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cause_q   <= '0;
      pc_q      <= '0;
      mstatus_q <= '0;
      mtvec_q   <= '0;
      mepc_q    <= '0;
      mret_q    <= 1'b0;
`ifdef CSR_TRAP_MTVAL_EN
      tval_q    <= '0;
`endif
      wren_q    <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      stall_q   <= 1'b0;
      flush_q   <= 1'b0;
      jump_en_q <= 1'b0;
      jump_pc_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      pc_q      <= pc_d;
      mstatus_q <= mstatus_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mret_q    <= mret_d;
`ifdef CSR_TRAP_MTVAL_EN
      tval_q    <= tval_d;
`endif
      wren_q    <= wren_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
      jump_en_q <= jump_en_d;
      jump_pc_q <= jump_pc_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.WREN    = wren_q;
  assign bus.WADDR   = waddr_q;
  assign bus.WDATA   = wdata_q;
  assign bus.STALL   = stall_q;
  assign bus.FLUSH   = flush_q;
  assign bus.JUMP_EN = jump_en_q;
  assign bus.JUMP_PC = jump_pc_q;
  assign bus.BUSY    = busy_q;

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Self-checking bench for csr_trap_sequencer: constant vector table, an
// asynchronous-reset abort sequence, and randomized ops against a reference model.
module tb_csr_trap_sequencer;

`ifdef CSR_TRAP_MTVAL_EN
  localparam bit MTVAL_ON = 1'b1;
`else
  localparam bit MTVAL_ON = 1'b0;
`endif
  localparam int unsigned NV = 8;
  localparam int unsigned NRAND = 150;

  typedef struct {
    logic        trap, mret, pipe;
    logic [11:0] paddr;
    logic [31:0] pdata, cause, pc, tval, mstatus, mtvec, mepc;
  } op_t;

  typedef struct {
    logic        wren;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        stall, flush, jump_en;
    logic [31:0] jump_pc;
    logic        busy;
  } out_t;

  typedef struct {
    string            name;
    op_t              op;
    int               nw;
    logic [0:3][11:0] wa;
    logic [0:3][31:0] wd;
    logic             jump;
    logic [31:0]      jpc;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  out_t exp_q[$];
  vec_t vecs[NV];

  csr_trap_sequencer_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  csr_trap_sequencer #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string nm, input string fld,
                              input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s: got 0x%08h want 0x%08h", nm, fld, act, exp);
    end
  endfunction

  function automatic out_t mk(input logic wren, input logic [11:0] a, input logic [31:0] d,
                              input logic stall, input logic flush, input logic jen,
                              input logic [31:0] jpc, input logic busy);
    out_t o;
    o.wren = wren; o.waddr = a; o.wdata = d; o.stall = stall;
    o.flush = flush; o.jump_en = jen; o.jump_pc = jpc; o.busy = busy;
    return o;
  endfunction

  function automatic op_t mkop(input logic trap, input logic mret, input logic pipe,
                               input logic [11:0] paddr, input logic [31:0] pdata,
                               input logic [31:0] cause, input logic [31:0] pc,
                               input logic [31:0] tval, input logic [31:0] ms,
                               input logic [31:0] mtvec, input logic [31:0] mepc);
    op_t o;
    o.trap = trap; o.mret = mret; o.pipe = pipe; o.paddr = paddr; o.pdata = pdata;
    o.cause = cause; o.pc = pc; o.tval = tval; o.mstatus = ms; o.mtvec = mtvec; o.mepc = mepc;
    return o;
  endfunction

  function automatic void check_out(input string nm, input out_t e);
    chk(nm, "WREN",    32'(bus.WREN),    32'(e.wren));
    chk(nm, "WADDR",   32'(bus.WADDR),   32'(e.waddr));
    chk(nm, "WDATA",   bus.WDATA,        e.wdata);
    chk(nm, "STALL",   32'(bus.STALL),   32'(e.stall));
    chk(nm, "FLUSH",   32'(bus.FLUSH),   32'(e.flush));
    chk(nm, "JUMP_EN", 32'(bus.JUMP_EN), 32'(e.jump_en));
    chk(nm, "JUMP_PC", bus.JUMP_PC,      e.jump_pc);
    chk(nm, "BUSY",    32'(bus.BUSY),    32'(e.busy));
  endfunction

  // Reference model: architectural rules expressed with plain arithmetic
  function automatic logic [31:0] ref_target(input logic [31:0] mtvec, input logic [31:0] cause);
    logic [63:0] m, c, base, t;
    m = {32'd0, mtvec};
    c = {32'd0, cause};
    base = m - (m % 64'd4);
    if ((m % 64'd4) == 64'd1 && c >= 64'h8000_0000) t = base + (c - 64'h8000_0000) * 64'd4;
    else t = base;
    return t[31:0];
  endfunction

  function automatic logic [31:0] ref_trap_ms(input logic [31:0] ms);
    logic [31:0] mie;
    mie = (ms >> 3) & 32'd1;
    return (ms & ~32'h0000_1888) | (mie << 7) | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] ref_mret_ms(input logic [31:0] ms);
    logic [31:0] mpie;
    mpie = (ms >> 7) & 32'd1;
    return (ms & ~32'h0000_1888) | (mpie << 3) | 32'h0000_0080 | 32'h0000_1800;
  endfunction

  function automatic void model(input op_t op);
    out_t idle;
    idle = mk(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    exp_q.delete();
    if (op.trap) begin
      exp_q.push_back(mk(1'b1, 12'h341, op.pc - (op.pc % 32'd4), 1'b1, 1'b0, 1'b0, '0, 1'b1));
      exp_q.push_back(mk(1'b1, 12'h342, op.cause, 1'b1, 1'b0, 1'b0, '0, 1'b1));
      if (MTVAL_ON) exp_q.push_back(mk(1'b1, 12'h343, op.tval, 1'b1, 1'b0, 1'b0, '0, 1'b1));
      exp_q.push_back(mk(1'b1, 12'h300, ref_trap_ms(op.mstatus), 1'b1, 1'b0, 1'b0, '0, 1'b1));
      exp_q.push_back(mk(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, ref_target(op.mtvec, op.cause), 1'b1));
    end else if (op.mret) begin
      exp_q.push_back(mk(1'b1, 12'h300, ref_mret_ms(op.mstatus), 1'b1, 1'b0, 1'b0, '0, 1'b1));
      exp_q.push_back(mk(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, op.mepc, 1'b1));
    end else if (op.pipe) begin
      exp_q.push_back(mk(1'b1, op.paddr, op.pdata, 1'b0, 1'b0, 1'b0, '0, 1'b0));
    end
    exp_q.push_back(idle);
  endfunction

  task automatic drive(input op_t op);
    bus.TRAP_EN    = op.trap;
    bus.MRET_EN    = op.mret;
    bus.PIPE_WREN  = op.pipe;
    bus.PIPE_WADDR = op.paddr;
    bus.PIPE_WDATA = op.pdata;
    bus.TRAP_CAUSE = op.cause;
    bus.TRAP_PC    = op.pc;
    bus.TRAP_TVAL  = op.tval;
    bus.MSTATUS_IN = op.mstatus;
    bus.MTVEC_IN   = op.mtvec;
    bus.MEPC_IN    = op.mepc;
  endtask

  task automatic clear_inputs();
    drive(mkop(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0, '0, '0));
  endtask

  task automatic drive_noise();
    drive(mkop(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               12'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom));
  endtask

  // Apply one op from IDLE and compare every following cycle to the model
  task automatic run_op(input string nm, input op_t op, input bit noise);
    model(op);
    drive(op);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check_out(nm, exp_q[i]);
      if (noise && exp_q[i].busy) drive_noise();
      else clear_inputs();
    end
  endtask

  task automatic fill_table();
    vecs[0].name = "pipe_write";
    vecs[0].op = mkop(1'b0, 1'b0, 1'b1, 12'h305, 32'h8000_0101, '0, '0, '0, '0, '0, '0);
    vecs[0].nw = 1; vecs[0].wa = {12'h305, 12'h0, 12'h0, 12'h0};
    vecs[0].wd = {32'h8000_0101, 32'h0, 32'h0, 32'h0};
    vecs[0].jump = 1'b0; vecs[0].jpc = '0;

    vecs[1].name = "trap_direct";
    vecs[1].op = mkop(1'b1, 1'b0, 1'b0, '0, '0, 32'd2, 32'h0000_1006, 32'hDEAD_BEEF,
                      32'h0000_0008, 32'h0000_0200, '0);
    vecs[1].nw = 4; vecs[1].wa = {12'h341, 12'h342, 12'h343, 12'h300};
    vecs[1].wd = {32'h0000_1004, 32'd2, 32'hDEAD_BEEF, 32'h0000_1880};
    vecs[1].jump = 1'b1; vecs[1].jpc = 32'h0000_0200;

    vecs[2].name = "trap_vectored";
    vecs[2].op = mkop(1'b1, 1'b0, 1'b0, '0, '0, 32'h8000_0007, 32'h0000_2000, 32'h0,
                      32'h0, 32'h0000_0201, '0);
    vecs[2].nw = 4; vecs[2].wa = {12'h341, 12'h342, 12'h343, 12'h300};
    vecs[2].wd = {32'h0000_2000, 32'h8000_0007, 32'h0, 32'h0000_1800};
    vecs[2].jump = 1'b1; vecs[2].jpc = 32'h0000_021C;

    vecs[3].name = "mret";
    vecs[3].op = mkop(1'b0, 1'b1, 1'b0, '0, '0, '0, '0, '0, 32'h0000_1880, '0, 32'h0000_1004);
    vecs[3].nw = 1; vecs[3].wa = {12'h300, 12'h0, 12'h0, 12'h0};
    vecs[3].wd = {32'h0000_1888, 32'h0, 32'h0, 32'h0};
    vecs[3].jump = 1'b1; vecs[3].jpc = 32'h0000_1004;

    vecs[4].name = "trap_mret_pipe_same_cycle";
    vecs[4].op = mkop(1'b1, 1'b1, 1'b1, 12'h305, 32'h0000_FFFF, 32'd3, 32'h0000_0040,
                      32'h0000_0055, 32'h0000_0088, 32'h0000_0100, 32'h0000_0999);
    vecs[4].nw = 4; vecs[4].wa = {12'h341, 12'h342, 12'h343, 12'h300};
    vecs[4].wd = {32'h0000_0040, 32'd3, 32'h0000_0055, 32'h0000_1880};
    vecs[4].jump = 1'b1; vecs[4].jpc = 32'h0000_0100;

    vecs[5].name = "trap_exception_vector_mode";
    vecs[5].op = mkop(1'b1, 1'b0, 1'b0, '0, '0, 32'd5, 32'h8000_0003, 32'h1,
                      32'hFFFF_FFFF, 32'h0000_0301, '0);
    vecs[5].nw = 4; vecs[5].wa = {12'h341, 12'h342, 12'h343, 12'h300};
    vecs[5].wd = {32'h8000_0000, 32'd5, 32'h1, 32'hFFFF_FFF7};
    vecs[5].jump = 1'b1; vecs[5].jpc = 32'h0000_0300;

    vecs[6].name = "mret_mpie_clear";
    vecs[6].op = mkop(1'b0, 1'b1, 1'b0, '0, '0, '0, '0, '0, 32'h0000_0008, '0, 32'h0000_1234);
    vecs[6].nw = 1; vecs[6].wa = {12'h300, 12'h0, 12'h0, 12'h0};
    vecs[6].wd = {32'h0000_1880, 32'h0, 32'h0, 32'h0};
    vecs[6].jump = 1'b1; vecs[6].jpc = 32'h0000_1234;

    vecs[7].name = "trap_vector_wrap";
    vecs[7].op = mkop(1'b1, 1'b0, 1'b0, '0, '0, 32'hFFFF_FFFF, 32'h0000_0007, 32'h2,
                      32'h0000_0080, 32'hFFFF_FF01, '0);
    vecs[7].nw = 4; vecs[7].wa = {12'h341, 12'h342, 12'h343, 12'h300};
    vecs[7].wd = {32'h0000_0004, 32'hFFFF_FFFF, 32'h2, 32'h0000_1800};
    vecs[7].jump = 1'b1; vecs[7].jpc = 32'hFFFF_FEFC;
  endtask

  initial begin
    out_t zero;
    op_t  op;
    int   kind;
    zero = mk(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    check_out("reset", zero);
    rst = 1'b0;
    @(negedge clk);
    check_out("after_reset", zero);

    fill_table();
    for (int v = 0; v < NV; v++) begin
      drive(vecs[v].op);
      for (int w = 0; w < vecs[v].nw; w++) begin
        if (!MTVAL_ON && vecs[v].wa[w] == 12'h343) continue;
        @(negedge clk);
        clear_inputs();
        check_out(vecs[v].name, mk(1'b1, vecs[v].wa[w], vecs[v].wd[w], vecs[v].jump,
                                   1'b0, 1'b0, '0, vecs[v].jump));
      end
      if (vecs[v].jump) begin
        @(negedge clk);
        check_out(vecs[v].name, mk(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, vecs[v].jpc, 1'b1));
      end
      @(negedge clk);
      check_out(vecs[v].name, zero);
    end

    // Asynchronous reset during the mcause write aborts the trap sequence
    drive(mkop(1'b1, 1'b0, 1'b0, '0, '0, 32'd11, 32'h0000_0800, 32'h7, 32'h8, 32'h400, '0));
    @(negedge clk);
    clear_inputs();
    check_out("rst_abort_mepc", mk(1'b1, 12'h341, 32'h0000_0800, 1'b1, 1'b0, 1'b0, '0, 1'b1));
    @(negedge clk);
    check_out("rst_abort_mcause", mk(1'b1, 12'h342, 32'd11, 1'b1, 1'b0, 1'b0, '0, 1'b1));
    #2 rst = 1'b1;
    #1 check_out("rst_abort_immediate", zero);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_out("rst_abort_quiet", zero);
    end
    run_op("rst_abort_then_pipe",
           mkop(1'b0, 1'b0, 1'b1, 12'h340, 32'h1234_5678, '0, '0, '0, '0, '0, '0), 1'b0);

    for (int k = 0; k < NRAND; k++) begin
      kind = int'($urandom_range(0, 5));
      op = mkop(1'b0, 1'b0, 1'b0, 12'($urandom), $urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom);
      op.mtvec[1:0] = 2'($urandom_range(0, 1));
      case (kind)
        0: op.pipe = 1'b1;
        1: op.trap = 1'b1;
        2: op.mret = 1'b1;
        3: begin op.trap = 1'b1; op.mret = 1'b1; op.pipe = 1'b1; end
        4: begin op.mret = 1'b1; op.pipe = 1'b1; end
        default: ;
      endcase
      run_op("random", op, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
